// File: rtl/mu01_mem_resp_if.sv
// Processor-side request/response bundle for the mu01_mem_resp word memory.
// The master drives req/we/addr/wdata and the slave returns ack/err/rdata/busy/out_port.
interface mu01_mem_resp_if;
    logic        req;
    logic        we;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic        ack;
    logic        err;
    logic [15:0] rdata;
    logic        busy;
    logic [15:0] out_port;

    modport master (
        output req, we, addr, wdata,
        input  ack, err, rdata, busy, out_port
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, err, rdata, busy, out_port
    );
endinterface

// File: rtl/mu01_mem_resp.sv
// 4096x16 wait-stated memory responder with write protection and an FFF mirror port.
// Latency: ack in the cycle after capture edge N+1+WAIT_STATES (N when WAIT_STATES=0).
// Backpressure: none; req is held until ack, and inputs are ignored while busy.
module mu01_mem_resp #(
    parameter int          WAIT_STATES = 1,
    parameter logic [11:0] PROT_LIMIT  = 12'h000
) (
    input  logic           clk,
    input  logic           reset,
    mu01_mem_resp_if.slave bus
);

    localparam logic [3:0]  WS       = 4'(WAIT_STATES);
    localparam logic [11:0] OUT_ADDR = 12'hFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        cap_we;
    logic [11:0] cap_addr;
    logic [15:0] cap_wdata;
    logic        ack_q;
    logic        err_q;
    logic        busy_q;
    logic [15:0] rdata_q;
    logic [15:0] out_q;

    // Contents survive reset, so the array carries no reset term.
    logic [15:0] mem [4096] = '{default: 16'h0000};

    // Borrow out of (a - PROT_LIMIT) means a < PROT_LIMIT; a zero limit never borrows.
    function automatic logic prot_hit(input logic [11:0] a);
        logic [12:0] diff;
        diff = {1'b0, a} - {1'b0, PROT_LIMIT};
        return diff[12];
    endfunction

    // In IDLE the live inputs feed the zero-wait path; otherwise the captured copy.
    logic        look_we;
    logic [11:0] look_addr;
    logic [15:0] look_word;
    logic        resp_err;
    logic        commit;

    always_comb begin
        look_we   = (state == IDLE) ? bus.we   : cap_we;
        look_addr = (state == IDLE) ? bus.addr : cap_addr;
        look_word = mem[look_addr];
        resp_err  = look_we && prot_hit(look_addr);
        commit    = (state == RESP) && cap_we && !prot_hit(cap_addr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            cap_we    <= 1'b0;
            cap_addr  <= 12'h000;
            cap_wdata <= 16'h0000;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            rdata_q   <= 16'h0000;
            out_q     <= 16'h0000;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        cap_we    <= bus.we;
                        cap_addr  <= bus.addr;
                        cap_wdata <= bus.wdata;
                        wait_cnt  <= WS;
                        busy_q    <= 1'b1;
                        if (WS == 4'd0) begin
                            state <= RESP;
                            ack_q <= 1'b1;
                            err_q <= resp_err;
                            if (!look_we) begin
                                rdata_q <= look_word;
                            end
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= RESP;
                        ack_q <= 1'b1;
                        err_q <= resp_err;
                        if (!look_we) begin
                            rdata_q <= look_word;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    if (commit && (cap_addr == OUT_ADDR)) begin
                        out_q <= cap_wdata;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // The reset term drops a write whose RESP was cut short by reset.
    always_ff @(posedge clk) begin
        if (reset && commit) begin
            mem[cap_addr] <= cap_wdata;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.err      = err_q;
    assign bus.rdata    = rdata_q;
    assign bus.busy     = busy_q;
    assign bus.out_port = out_q;

endmodule

// File: tb/tb_mu01_mem_resp.sv
// Scoreboard bench for mu01_mem_resp: three parameterisations driven by directed vectors.
module tb_mu01_mem_resp;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mu01_mem_resp_if if0();
    mu01_mem_resp_if if1();
    mu01_mem_resp_if if2();

    logic        req_s   [3];
    logic        we_s    [3];
    logic [11:0] addr_s  [3];
    logic [15:0] wdata_s [3];
    logic        ack_w   [3];
    logic        err_w   [3];
    logic        busy_w  [3];
    logic [15:0] rdata_w [3];
    logic [15:0] outp_w  [3];

    assign if0.req = req_s[0];  assign if0.we = we_s[0];
    assign if0.addr = addr_s[0]; assign if0.wdata = wdata_s[0];
    assign if1.req = req_s[1];  assign if1.we = we_s[1];
    assign if1.addr = addr_s[1]; assign if1.wdata = wdata_s[1];
    assign if2.req = req_s[2];  assign if2.we = we_s[2];
    assign if2.addr = addr_s[2]; assign if2.wdata = wdata_s[2];

    assign ack_w[0] = if0.ack; assign err_w[0] = if0.err; assign busy_w[0] = if0.busy;
    assign rdata_w[0] = if0.rdata; assign outp_w[0] = if0.out_port;
    assign ack_w[1] = if1.ack; assign err_w[1] = if1.err; assign busy_w[1] = if1.busy;
    assign rdata_w[1] = if1.rdata; assign outp_w[1] = if1.out_port;
    assign ack_w[2] = if2.ack; assign err_w[2] = if2.err; assign busy_w[2] = if2.busy;
    assign rdata_w[2] = if2.rdata; assign outp_w[2] = if2.out_port;

    // dut0: one wait state, unprotected; dut1: zero wait; dut2: two waits, limit 0x040.
    mu01_mem_resp #(.WAIT_STATES(1), .PROT_LIMIT(12'h000)) u0 (.clk(clk), .reset(reset), .bus(if0));
    mu01_mem_resp #(.WAIT_STATES(0), .PROT_LIMIT(12'h000)) u1 (.clk(clk), .reset(reset), .bus(if1));
    mu01_mem_resp #(.WAIT_STATES(2), .PROT_LIMIT(12'h040)) u2 (.clk(clk), .reset(reset), .bus(if2));

    typedef struct packed {
        logic        rd;
        logic        err;
        logic [15:0] rdata;
    } exp_t;

    exp_t exp_q [3][$];
    int checks = 0;
    int errors = 0;

    function automatic int lat_of(input int d);
        case (d)
            0:       return 3;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
        end
    endtask

    // Starts at a negedge with the DUT idle; returns at the negedge showing ack.
    task automatic txn(input int d, input logic w, input logic [11:0] a, input logic [15:0] wd,
                       input logic e_err, input logic [15:0] e_rd, input logic keep,
                       input int e_lat, input logic scramble);
        exp_t x;
        int   n;
        req_s[d]   = 1'b1;
        we_s[d]    = w;
        addr_s[d]  = a;
        wdata_s[d] = wd;
        x.rd    = !w;
        x.err   = e_err;
        x.rdata = e_rd;
        exp_q[d].push_back(x);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1 && e_lat == lat_of(d) && e_lat > 1)
                check($sformatf("busy_in_wait dut%0d", d), 32'(busy_w[d]), 32'd1);
            if (n == 1 && scramble) begin
                addr_s[d]  = a + 12'h001;
                wdata_s[d] = 16'hFFFF;
            end
        end while (ack_w[d] !== 1'b1 && n < 20);
        check($sformatf("latency dut%0d addr %0h", d, a), 32'(n), 32'(e_lat));
        if (!keep) req_s[d] = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t x;
        for (int d = 0; d < 3; d++) begin
            if (ack_w[d] === 1'b1) begin
                if (exp_q[d].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack dut%0d actual=1 required=0", d);
                end else begin
                    x = exp_q[d].pop_front();
                    check($sformatf("err dut%0d", d), 32'(err_w[d]), 32'(x.err));
                    if (x.rd)
                        check($sformatf("rdata dut%0d", d), 32'(rdata_w[d]), 32'(x.rdata));
                end
            end else begin
                check($sformatf("err_without_ack dut%0d", d), 32'(err_w[d]), 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            req_s[d] = 1'b0; we_s[d] = 1'b0; addr_s[d] = 12'h000; wdata_s[d] = 16'h0000;
        end
        #12;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_ack dut%0d", d),   32'(ack_w[d]),   32'd0);
            check($sformatf("rst_err dut%0d", d),   32'(err_w[d]),   32'd0);
            check($sformatf("rst_busy dut%0d", d),  32'(busy_w[d]),  32'd0);
            check($sformatf("rst_rdata dut%0d", d), 32'(rdata_w[d]), 32'd0);
            check($sformatf("rst_out dut%0d", d),   32'(outp_w[d]),  32'd0);
        end
        @(negedge clk);
        reset = 1'b1;

        // One wait state: write then read back, then the FFF mirror port.
        txn(0, 1'b1, 12'h010, 16'h1234, 1'b0, 16'h0000, 1'b0, 3, 1'b0);
        @(negedge clk);
        txn(0, 1'b0, 12'h010, 16'h0000, 1'b0, 16'h1234, 1'b0, 3, 1'b0);
        @(negedge clk);
        txn(0, 1'b1, 12'hFFF, 16'h0006, 1'b0, 16'h0000, 1'b0, 3, 1'b0);
        check("out_port_before_commit", 32'(outp_w[0]), 32'h0000);
        @(negedge clk);
        check("out_port_after_commit", 32'(outp_w[0]), 32'h0006);
        txn(0, 1'b0, 12'hFFF, 16'h0000, 1'b0, 16'h0006, 1'b0, 3, 1'b0);

        // Zero wait states with req held high across four transactions.
        @(negedge clk);
        txn(1, 1'b1, 12'h020, 16'h0003, 1'b0, 16'h0000, 1'b1, 1, 1'b0);
        txn(1, 1'b0, 12'h020, 16'h0000, 1'b0, 16'h0003, 1'b1, 2, 1'b0);
        txn(1, 1'b1, 12'h020, 16'h0005, 1'b0, 16'h0000, 1'b1, 2, 1'b0);
        txn(1, 1'b0, 12'h020, 16'h0000, 1'b0, 16'h0005, 1'b0, 2, 1'b0);

        // Protection at 0x040: below rejected, boundary accepted.
        @(negedge clk);
        txn(2, 1'b1, 12'h005, 16'hBEEF, 1'b1, 16'h0000, 1'b0, 4, 1'b0);
        @(negedge clk);
        txn(2, 1'b0, 12'h005, 16'h0000, 1'b0, 16'h0000, 1'b0, 4, 1'b0);
        @(negedge clk);
        txn(2, 1'b1, 12'h040, 16'h1111, 1'b0, 16'h0000, 1'b0, 4, 1'b0);
        @(negedge clk);
        txn(2, 1'b0, 12'h040, 16'h0000, 1'b0, 16'h1111, 1'b0, 4, 1'b0);
        @(negedge clk);
        txn(2, 1'b1, 12'h03F, 16'h2222, 1'b1, 16'h0000, 1'b0, 4, 1'b0);
        @(negedge clk);
        txn(2, 1'b0, 12'h03F, 16'h0000, 1'b0, 16'h0000, 1'b0, 4, 1'b0);

        // Reset during WAIT aborts the write with no ack.
        @(negedge clk);
        req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 12'h030; wdata_s[0] = 16'hAAAA;
        @(negedge clk);
        check("abort_busy_before", 32'(busy_w[0]), 32'd1);
        reset = 1'b0;
        #1;
        check("abort_busy_now", 32'(busy_w[0]), 32'd0);
        check("abort_ack_now",  32'(ack_w[0]),  32'd0);
        req_s[0] = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        txn(0, 1'b0, 12'h030, 16'h0000, 1'b0, 16'h0000, 1'b0, 3, 1'b0);

        // Inputs disturbed during WAIT must not leak into the captured write.
        @(negedge clk);
        txn(0, 1'b1, 12'h011, 16'h0001, 1'b0, 16'h0000, 1'b0, 3, 1'b1);
        @(negedge clk);
        txn(0, 1'b0, 12'h011, 16'h0000, 1'b0, 16'h0001, 1'b0, 3, 1'b0);
        @(negedge clk);
        txn(0, 1'b0, 12'h012, 16'h0000, 1'b0, 16'h0000, 1'b0, 3, 1'b0);

        repeat (4) @(negedge clk);
        for (int d = 0; d < 3; d++)
            check($sformatf("pending_resp dut%0d", d), 32'(exp_q[d].size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mu01_mem_resp.md
MU01_MEM_RESP -- requirements
Module: mu01_mem_resp

Interface
REQ-001 Parameter WAIT_STATES, default 1: number of idle cycles inserted between request capture and acknowledge (legal range 0..15).
REQ-002 Parameter PROT_LIMIT, default 12'h000: writes to addresses below this value are rejected; 12'h000 disables protection.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low forces reset state immediately, release is synchronous to clk.
REQ-005 req  input  1  request valid from processor; held high until ack.
REQ-006 we  input  1  1 = write (store), 0 = read (fetch/load).
REQ-007 addr  input  12  word address into 4096-entry memory.
REQ-008 wdata  input  16  write data, meaningful when we=1.
REQ-009 ack  output  1  one-cycle completion pulse.
REQ-010 err  output  1  valid with ack; 1 = write rejected by protection.
REQ-011 rdata  output  16  read data, valid in the ack cycle of a read.
REQ-012 busy  output  1  high whenever FSM is not IDLE.
REQ-013 out_port  output  16  mirror of last accepted write to address 12'hFFF.

Function
REQ-014 Storage SHALL be 4096 x 16 words; all locations zero at time zero; reset SHALL NOT modify memory contents.
REQ-015 FSM states SHALL be IDLE, WAIT, RESP.
REQ-016 IDLE: req=1 at a rising edge captures we/addr/wdata into internal registers, loads wait counter with WAIT_STATES, goes to WAIT (or RESP if WAIT_STATES=0); req=0 stays IDLE.
REQ-017 WAIT: counter decrements each cycle; goes to RESP on the edge where counter reaches 0.
REQ-018 RESP: ack=1 for exactly this one cycle; unconditional return to IDLE next edge.
REQ-019 Latency: req sampled high at edge N SHALL give ack high in the cycle following edge N+1+WAIT_STATES (ack one cycle after edge N when WAIT_STATES=0).
REQ-020 Input changes on addr/we/wdata/req after capture SHALL be ignored until FSM returns to IDLE.
REQ-021 Read: rdata SHALL present mem[captured addr] during the RESP cycle and hold that value until the next read completes; err=0.
REQ-022 Write, addr >= PROT_LIMIT: mem[addr] SHALL be written at the edge ending RESP; err=0; rdata unchanged.
REQ-023 Write, addr < PROT_LIMIT: no memory update, err=1 in RESP cycle, out_port unchanged.
REQ-024 Accepted write to 12'hFFF SHALL update out_port at the same edge the memory is written.
REQ-025 err SHALL be 0 whenever ack=0.
REQ-026 req still high in the cycle after ack SHALL be treated as a new request captured in IDLE (minimum 2+WAIT_STATES cycles per transaction).
REQ-027 Read of an address written by the immediately preceding transaction SHALL return the new data.
REQ-028 busy SHALL equal (state != IDLE).

Reset
REQ-029 While reset=0: state=IDLE, ack=0, err=0, busy=0, rdata=16'h0000, out_port=16'h0000, wait counter=0.
REQ-030 Reset asserted in WAIT or RESP SHALL abort the transaction with no memory write and no ack pulse.
REQ-031 First request is accepted at the first rising edge with reset=1 and req=1.

Verification
REQ-032 WAIT_STATES=1: write addr 12'h010 data 16'h1234 -> ack on 3rd cycle after req edge, err=0; then read 12'h010 -> rdata=16'h1234 with ack.
REQ-033 Write 16'h0006 to 12'hFFF -> out_port=16'h0006 after ack edge; read 12'hFFF -> rdata=16'h0006.
REQ-034 PROT_LIMIT=12'h040: write 16'hBEEF to 12'h005 -> ack with err=1; read 12'h005 -> rdata=16'h0000, err=0.
REQ-035 WAIT_STATES=0, req held high for four transactions (write 12'h020=16'h0003, then read 12'h020) -> ack every second cycle, read returns 16'h0003.
REQ-036 Assert reset=0 during WAIT of a write of 16'hAAAA to 12'h030 -> no ack, busy=0 immediately; later read of 12'h030 -> 16'h0000.
REQ-037 Change addr/wdata during WAIT of a write to 12'h011 (16'h0001) -> only mem[12'h011]=16'h0001 updated.
